// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main control: opcodes, FSM states,
// datapath select codes and the packed control word produced per state.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  // ready_gate marks states whose write enables / retire wait on mem_ready.
  typedef struct packed {
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        retire;
    logic        illegal;
    logic        ready_gate;
    src_a_t      src_a;
    src_b_t      src_b;
    alu_op_t     alu_op;
    result_src_t result_src;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure Moore decode: maps the current FSM state to the raw datapath control word.
module mc_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  state_t     state_i,
  output ctrl_word_t ctrl_o
);

  // Per-state control word; every field not set below stays 0.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_update  = 1'b1;
        ctrl_o.ready_gate = 1'b1;
        ctrl_o.src_a      = SRCA_PC;
        ctrl_o.src_b      = SRCB_FOUR;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl_o.src_a  = SRCA_OLDPC;
        ctrl_o.src_b  = SRCB_IMM;
        ctrl_o.alu_op = ALU_ADD;
      end
      S_MEMADR, S_EXEC_I: begin
        ctrl_o.src_a  = SRCA_RD1;
        ctrl_o.src_b  = SRCB_IMM;
        ctrl_o.alu_op = (state_i == S_EXEC_I) ? ALU_FUNCT : ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.ready_gate = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.retire     = 1'b1;
        ctrl_o.ready_gate = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_EXEC_R: begin
        ctrl_o.src_a  = SRCA_RD1;
        ctrl_o.src_b  = SRCB_RD2;
        ctrl_o.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.src_a      = SRCA_RD1;
        ctrl_o.src_b      = SRCB_RD2;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_JAL: begin
        ctrl_o.src_a      = SRCA_OLDPC;
        ctrl_o.src_b      = SRCB_FOUR;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for the multicycle RV32I datapath: state register,
// opcode-driven sequencing and mem_ready / zero gating of the decoded controls.
module multicycle_main_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t ctrl_s;
  logic       ready_ok_s;

  mc_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing from opcode and the memory handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_JAL:    state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_TRAP: state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
  end

  // Handshake-sensitive strobes only fire once memory completes the access.
  assign ready_ok_s = ~ctrl_s.ready_gate | mem_ready;

  assign mem_req       = ctrl_s.mem_req;
  assign mem_write     = ctrl_s.mem_write;
  assign adr_src       = ctrl_s.adr_src;
  assign ir_write      = ctrl_s.ir_write & ready_ok_s;
  assign pc_write      = (ctrl_s.pc_update & ready_ok_s) | (ctrl_s.branch & zero);
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.src_a;
  assign alu_src_b     = ctrl_s.src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign result_src    = ctrl_s.result_src;
  assign instr_retired = ctrl_s.retire & ready_ok_s;
  assign illegal_instr = ctrl_s.illegal;

endmodule
